// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback stage.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_ALU,
    SEL_LOAD,
    SEL_FORCE
  } wb_sel_e;

endpackage

// File: rtl/wb_if.sv
// Bus bundle between the execute units, the writeback stage and the register file write port.
interface wb_if;
  import wb_pkg::*;

  logic                  iAluValid;
  logic [REG_ADDR_W-1:0] iAluAddr;
  logic [XLEN-1:0]       iAluData;
  logic                  oAluStall;
  logic                  iLdValid;
  logic                  oLdReady;
  logic [REG_ADDR_W-1:0] iLdAddr;
  logic [XLEN-1:0]       iLdData;
  logic                  oWrite;
  logic [REG_ADDR_W-1:0] oAddrC;
  logic [XLEN-1:0]       oRegC;

  modport master (
    output iAluValid, iAluAddr, iAluData, iLdValid, iLdAddr, iLdData,
    input  oAluStall, oLdReady, oWrite, oAddrC, oRegC
  );

  modport slave (
    input  iAluValid, iAluAddr, iAluData, iLdValid, iLdAddr, iLdData,
    output oAluStall, oLdReady, oWrite, oAddrC, oRegC
  );

endinterface

// File: rtl/wb_fifo.sv
// Load-result FIFO; exposes per-entry address/valid so the top can keep same-register writes in order.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_req_t               push_req,
  input  logic                  pop,
  output wb_req_t               head,
  output logic                  full,
  output logic                  empty,
  output logic [REG_ADDR_W-1:0] entry_addr [DEPTH],
  output logic [DEPTH-1:0]      entry_valid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage needs no reset: entry_valid alone says which slots mean anything.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  // Pointers wrap naturally (DEPTH is a power of two); valid bits track occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      entry_valid <= '0;
    end else begin
      if (push) begin
        wr_ptr              <= wr_ptr + PW'(1);
        entry_valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr              <= rd_ptr + PW'(1);
        entry_valid[rd_ptr] <= 1'b0;
      end
    end
  end

  // Address view of every slot for the scoreboard compare.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_addr[i] = mem[i].addr;
  end

  assign head  = mem[rd_ptr];
  assign full  = &entry_valid;
  assign empty = ~|entry_valid;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: merges ALU and load results onto the single register file write port.
// Optional feature macro WB_FWD_EN adds a same-cycle forwarding port for the decode stage.
module wb_stage
  import wb_pkg::*;
#(
  parameter int LD_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  iClk,
  input  logic                  nRst,
  wb_if.slave                   wb
`ifdef WB_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0] iFwdAddr,
  output logic                  oFwdHit,
  output logic [XLEN-1:0]       oFwdData
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  wb_sel_e               sel;
  wb_req_t               head;
  logic                  full;
  logic                  empty;
  logic [REG_ADDR_W-1:0] entry_addr [LD_DEPTH];
  logic [LD_DEPTH-1:0]   entry_valid;
  logic                  ld_push;
  logic                  pop;
  logic                  alu_live;
  logic                  order_hit;
  logic                  force_head;
  logic [SW-1:0]         starve_cnt;

  // Register-0 traffic never occupies the port: ALU r0 is simply consumed, load r0 is dropped.
  assign alu_live    = wb.iAluValid && (wb.iAluAddr != '0);
  assign ld_push     = wb.iLdValid && !full && (wb.iLdAddr != '0);
  assign wb.oLdReady = !full;
  assign force_head  = (starve_cnt == STARVE_MAX) && !empty;

  wb_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
    .clk         (iClk),
    .rst_n       (nRst),
    .push        (ld_push),
    .push_req    ('{addr: wb.iLdAddr, data: wb.iLdData}),
    .pop         (pop),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .entry_addr  (entry_addr),
    .entry_valid (entry_valid)
  );

  // Scoreboard: an ALU write to a register with an older queued load must wait for the FIFO to drain past it.
  always_comb begin
    order_hit = 1'b0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == wb.iAluAddr)) order_hit = 1'b1;
    end
    order_hit = order_hit && alu_live;
  end

  // Port arbitration: forced head, then ordering hazard, then ALU, then plain load drain.
  always_comb begin
    sel          = SEL_IDLE;
    pop          = 1'b0;
    wb.oAluStall = 1'b0;
    if (force_head) begin
      sel          = SEL_FORCE;
      pop          = 1'b1;
      wb.oAluStall = alu_live;
    end else if (order_hit) begin
      sel          = SEL_LOAD;
      pop          = 1'b1;
      wb.oAluStall = 1'b1;
    end else if (alu_live) begin
      sel = SEL_ALU;
    end else if (!empty) begin
      sel = SEL_LOAD;
      pop = 1'b1;
    end
  end

  // Counts cycles a queued head is passed over; saturates so FORCE stays asserted until it dequeues.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Output register; address and data hold on idle cycles.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      wb.oWrite <= 1'b0;
      wb.oAddrC <= '0;
      wb.oRegC  <= '0;
    end else begin
      case (sel)
        SEL_IDLE: wb.oWrite <= 1'b0;
        SEL_ALU: begin
          wb.oWrite <= 1'b1;
          wb.oAddrC <= wb.iAluAddr;
          wb.oRegC  <= wb.iAluData;
        end
        default: begin
          wb.oWrite <= 1'b1;
          wb.oAddrC <= head.addr;
          wb.oRegC  <= head.data;
        end
      endcase
    end
  end

`ifdef WB_FWD_EN
  assign oFwdHit  = wb.oWrite && (wb.oAddrC == iFwdAddr) && (iFwdAddr != '0);
  assign oFwdData = wb.oRegC;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;
  import wb_pkg::*;

  logic iClk = 1'b0;
  logic nRst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] rf [32];

  wb_if bus ();

`ifdef WB_FWD_EN
  logic [4:0]  iFwdAddr = '0;
  logic        oFwdHit;
  logic [31:0] oFwdData;
`endif

  wb_stage #(.LD_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .iClk (iClk),
    .nRst (nRst),
    .wb   (bus)
`ifdef WB_FWD_EN
    ,
    .iFwdAddr (iFwdAddr),
    .oFwdHit  (oFwdHit),
    .oFwdData (oFwdData)
`endif
  );

  always #5 iClk = ~iClk;

  // Register file model fed by the write port.
  always @(posedge iClk) begin
    if (bus.oWrite) rf[bus.oAddrC] <= bus.oRegC;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".write"}, 32'(bus.oWrite), 32'(w));
    chk({tag, ".addr"},  32'(bus.oAddrC), 32'(a));
    chk({tag, ".data"},  bus.oRegC, d);
  endtask

  task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.iAluValid = v; bus.iAluAddr = a; bus.iAluData = d;
  endtask

  task automatic ld(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.iLdValid = v; bus.iLdAddr = a; bus.iLdData = d;
  endtask

  initial begin
    alu(0, 0, 0);
    ld(0, 0, 0);
    #12;
    chk_wr("reset", 0, 0, 0);
    chk("reset.ready", 32'(bus.oLdReady), 1);
    chk("reset.stall", 32'(bus.oAluStall), 0);
    nRst = 1'b1;
    tick();

    // ALU r3 = 0xAA, one-cycle latency
    alu(1, 3, 32'hAA); #1;
    chk("alu.stall", 32'(bus.oAluStall), 0);
    tick(); alu(0, 0, 0);
    chk_wr("alu.n1", 1, 3, 32'hAA);
`ifdef WB_FWD_EN
    iFwdAddr = 3; #1;
    chk("fwd.hit", 32'(oFwdHit), 1);
    chk("fwd.data", oFwdData, 32'hAA);
    iFwdAddr = 0; #1;
    chk("fwd.zero", 32'(oFwdHit), 0);
`endif
    tick();
    chk_wr("alu.n2", 0, 3, 32'hAA);

    // Load r5 = 0x1234, two-cycle latency
    ld(1, 5, 32'h1234); #1;
    chk("ld.ready", 32'(bus.oLdReady), 1);
    tick(); ld(0, 0, 0);
    chk("ld.n1", 32'(bus.oWrite), 0);
    tick();
    chk_wr("ld.n2", 1, 5, 32'h1234);
    tick();
    chk("ld.n3", 32'(bus.oWrite), 0);

    // Same-register ordering: load r7=1 then ALU r7=2
    ld(1, 7, 32'd1);
    tick(); ld(0, 0, 0);
    alu(1, 7, 32'd2); #1;
    chk("ord.stall1", 32'(bus.oAluStall), 1);
    tick();
    chk_wr("ord.first", 1, 7, 32'd1);
    chk("ord.stall2", 32'(bus.oAluStall), 0);
    tick(); alu(0, 0, 0);
    chk_wr("ord.second", 1, 7, 32'd2);
    tick();
    chk("ord.rf7", rf[7], 32'd2);

    // Starvation: ALU r1 every cycle, load r9 forced after 4 waiting cycles
    ld(1, 9, 32'h99);
    alu(1, 1, 32'h100); #1;
    chk("st.stall0", 32'(bus.oAluStall), 0);
    tick(); ld(0, 0, 0);
    chk_wr("st.alu0", 1, 1, 32'h100);
    for (int i = 1; i <= 4; i++) begin
      alu(1, 1, 32'h100 + 32'(i)); #1;
      chk("st.stall_wait", 32'(bus.oAluStall), 0);
      tick();
      chk_wr("st.alu_wait", 1, 1, 32'h100 + 32'(i));
    end
    alu(1, 1, 32'h105); #1;
    chk("st.stall_force", 32'(bus.oAluStall), 1);
    tick();
    chk_wr("st.forced", 1, 9, 32'h99);
    chk("st.stall_after", 32'(bus.oAluStall), 0);
    tick(); alu(0, 0, 0);
    chk_wr("st.resume", 1, 1, 32'h105);
    tick();

    // Full FIFO: three loads while ALU keeps r2 busy
    alu(1, 2, 32'h22);
    ld(1, 10, 32'hA0); #1;
    chk("full.rdy_a", 32'(bus.oLdReady), 1);
    tick();
    ld(1, 11, 32'hB0); #1;
    chk("full.rdy_b", 32'(bus.oLdReady), 1);
    tick();
    ld(1, 12, 32'hC0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full.rdy_wait", 32'(bus.oLdReady), 0);
      chk("full.stall_wait", 32'(bus.oAluStall), 0);
      tick();
      chk_wr("full.alu", 1, 2, 32'h22);
    end
    #1;
    chk("full.rdy_force", 32'(bus.oLdReady), 0);
    chk("full.stall_force", 32'(bus.oAluStall), 1);
    tick();
    chk_wr("full.deq10", 1, 10, 32'hA0);
    chk("full.rdy_after", 32'(bus.oLdReady), 1);
    tick(); ld(0, 0, 0); alu(0, 0, 0);
    chk_wr("full.alu2", 1, 2, 32'h22);
    tick();
    chk_wr("full.deq11", 1, 11, 32'hB0);
    tick();
    chk_wr("full.deq12", 1, 12, 32'hC0);
    tick();
    chk("full.idle", 32'(bus.oWrite), 0);

    // Register 0 traffic is discarded
    alu(1, 0, 32'hDEAD);
    ld(1, 0, 32'hBEEF); #1;
    chk("r0.stall", 32'(bus.oAluStall), 0);
    chk("r0.ready", 32'(bus.oLdReady), 1);
    tick(); alu(0, 0, 0); ld(0, 0, 0);
    chk_wr("r0.n1", 0, 12, 32'hC0);
    tick();
    chk("r0.n2", 32'(bus.oWrite), 0);

    // Reset mid-operation loses the queued load
    alu(1, 6, 32'h66);
    ld(1, 4, 32'h44);
    tick(); alu(0, 0, 0); ld(0, 0, 0);
    chk_wr("rst.pre", 1, 6, 32'h66);
    #2 nRst = 1'b0;
    #1;
    chk_wr("rst.async", 0, 0, 0);
    chk("rst.ready", 32'(bus.oLdReady), 1);
    tick();
    nRst = 1'b1;
    tick();
    chk("rst.post1", 32'(bus.oWrite), 0);
    tick();
    chk("rst.post2", 32'(bus.oWrite), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
